// File: rtl/fir_tdm_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
// The FIR_TDM_SATURATE_EN macro selects output clamping in the top module.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StMac,
    StOut
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Channel index width, never below one bit.
  function automatic int unsigned ch_width(input int unsigned ch);
    return (clog2(ch) > 0) ? clog2(ch) : 1;
  endfunction

  // Accumulator width that cannot overflow over all taps.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Clamp a signed value into the w-bit two's-complement range.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_tdm_filter_if.sv
// Sample, result and coefficient-load signals of fir_tdm_filter.
interface fir_tdm_filter_if
  import fir_tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 32,
  parameter int unsigned CH     = 2
);
  localparam int unsigned TapsW = clog2(TAPS);
  localparam int unsigned ChW   = ch_width(CH);

  logic              coef_we;
  logic [TapsW-1:0]  coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              in_valid;
  logic              in_ready;
  logic [ChW-1:0]    in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [ChW-1:0]    out_ch;
  logic [DATA_W-1:0] out_data;

  modport master (
    output coef_we, coef_addr, coef_data, in_valid, in_ch, in_data,
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, in_valid, in_ch, in_data,
    output in_ready, out_valid, out_ch, out_data
  );

endinterface

// File: rtl/fir_hist_ram.sv
// Simple dual-port history RAM: one write port, one registered read port.
module fir_hist_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; data appears the cycle after the address.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tdm_filter.sv
// Multi-channel FIR with one shared MAC. Each channel keeps a circular history
// in fir_hist_ram; coefficients are shared. Define FIR_TDM_SATURATE_EN to clamp
// the shifted result instead of wrapping it to DATA_W bits.
module fir_tdm_filter
  import fir_tdm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 32,
  parameter int unsigned CH     = 2,
  parameter int unsigned SHIFT  = 16
) (
  input logic clk,
  input logic rst,
  fir_tdm_filter_if.slave bus_io
);

  localparam int unsigned TapsW = clog2(TAPS);
  localparam int unsigned ChW   = ch_width(CH);
  localparam int unsigned AddrW = ChW + TapsW;
  localparam int unsigned Depth = TAPS * CH;
  localparam int unsigned ProdW = DATA_W + COEF_W;
  localparam int unsigned AccW  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int unsigned KW    = TapsW + 1;

  localparam logic [AddrW-1:0] LastInit = AddrW'(Depth - 1);
  localparam logic [AddrW-1:0] InitTaps = AddrW'(TAPS);
  localparam logic [KW-1:0]    TapsK    = KW'(TAPS);
  localparam logic [KW-1:0]    LastK    = KW'(TAPS + 1);

  state_e                    state_q;
  logic [AddrW-1:0]          cnt_q;
  logic [KW-1:0]             k_q;
  logic [ChW-1:0]            ch_q;
  logic [TapsW-1:0]          wptr_q [CH];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic signed [COEF_W-1:0]  coef_rd_q;
  logic signed [ProdW-1:0]   prod_q;
  logic signed [AccW-1:0]    acc_q;
  logic                      rd_vld_q, prod_vld_q;
  logic                      in_ready_q, out_valid_q;
  logic [ChW-1:0]            out_ch_q;
  logic [DATA_W-1:0]         out_data_q;

  logic                      accept, ch_ok;
  logic                      ram_we;
  logic [AddrW-1:0]          ram_waddr, ram_raddr;
  logic [DATA_W-1:0]         ram_wdata, ram_rdata;
  logic signed [ProdW-1:0]   prod_d;
  logic signed [AccW-1:0]    acc_fin, acc_sh;
  logic [DATA_W-1:0]         result;
`ifdef FIR_TDM_SATURATE_EN
  logic signed [63:0]        sat_wide;
`endif

  fir_hist_ram #(
    .Width (DATA_W),
    .Depth (Depth),
    .AddrW (AddrW)
  ) u_hist (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // History write/read addressing: INIT clears, IDLE accept stores the sample.
  always_comb begin
    accept    = (state_q == StIdle) && bus_io.in_valid;
    ch_ok     = (32'(bus_io.in_ch) < CH);
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_q == StInit) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
    end else if (accept && ch_ok) begin
      ram_we    = 1'b1;
      ram_waddr = {bus_io.in_ch, wptr_q[bus_io.in_ch]};
      ram_wdata = bus_io.in_data;
    end
    // Tap k reads the sample k steps older than the newest one.
    ram_raddr = {ch_q, wptr_q[ch_q] - k_q[TapsW-1:0]};
  end

  // Product, final accumulation and output scaling.
  always_comb begin
    prod_d  = $signed({{COEF_W{ram_rdata[DATA_W-1]}}, ram_rdata}) *
              $signed({{DATA_W{coef_rd_q[COEF_W-1]}}, coef_rd_q});
    acc_fin = acc_q + $signed({{(AccW - ProdW){prod_q[ProdW-1]}}, prod_q});
    acc_sh  = acc_fin >>> SHIFT;
`ifdef FIR_TDM_SATURATE_EN
    sat_wide = sat_clamp({{(64 - AccW){acc_sh[AccW-1]}}, acc_sh}, DATA_W);
    result   = sat_wide[DATA_W-1:0];
`else
    result   = acc_sh[DATA_W-1:0];
`endif
  end

  // Coefficient store: cleared during INIT, writable only in IDLE.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      if (cnt_q < InitTaps) coef_q[cnt_q[TapsW-1:0]] <= '0;
    end else if (state_q == StIdle && bus_io.coef_we) begin
      coef_q[bus_io.coef_addr] <= bus_io.coef_data;
    end
  end

  // Control FSM with the MAC pipeline and registered outputs.
  // MAC runs TAPS+2 cycles: TAPS reads, one RAM read latency, one product drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      coef_rd_q   <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      rd_vld_q    <= 1'b0;
      prod_vld_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < int'(CH); i++) wptr_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastInit) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
          end
        end
        StIdle: begin
          // Out-of-range channels are consumed silently and leave us in IDLE.
          if (accept && ch_ok) begin
            state_q    <= StMac;
            in_ready_q <= 1'b0;
            ch_q       <= bus_io.in_ch;
            acc_q      <= '0;
            k_q        <= '0;
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
          end
        end
        StMac: begin
          k_q        <= k_q + 1'b1;
          rd_vld_q   <= (k_q < TapsK);
          coef_rd_q  <= coef_q[k_q[TapsW-1:0]];
          prod_vld_q <= rd_vld_q;
          prod_q     <= prod_d;
          if (prod_vld_q) acc_q <= acc_fin;
          if (k_q == LastK) begin
            state_q      <= StOut;
            out_valid_q  <= 1'b1;
            out_ch_q     <= ch_q;
            out_data_q   <= result;
            wptr_q[ch_q] <= wptr_q[ch_q] + 1'b1;
          end
        end
        StOut: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_ch    = out_ch_q;
  assign bus_io.out_data  = out_data_q;

endmodule
